// File: rtl/accum_table_pkg.sv
// ---------------------------------------------------------------------------
// wordcount_pkg
// Shared types and widths for the accum_table count store.
//   ACCUM_DIN_W : width of the update word (init flag + increment)
//   COUNT_W     : width of one stored counter
//   accum_req_t : decoded update request
//   accum_state_t : table controller states
// ---------------------------------------------------------------------------
package wordcount_pkg;

    localparam int ACCUM_DIN_W = 65;
    localparam int COUNT_W     = 64;

    typedef struct packed {
        logic               init;
        logic [COUNT_W-1:0] increment;
        logic [31:0]        addr;
    } accum_req_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } accum_state_t;

endpackage

// File: rtl/accum_table_if.sv
// ---------------------------------------------------------------------------
// accum_table_if
// Update stream, read port and status of the accum_table count store.
//   master : upstream/host side (drives updates, clear and read requests)
//   slave  : table side (drives ready, read data and error flag)
// ---------------------------------------------------------------------------
interface accum_table_if
    import wordcount_pkg::*;
#(
    parameter int ADDR_W = 10
) ();

    logic [31:0]            accum_addr;
    logic [ACCUM_DIN_W-1:0] accum_din;
    logic                   accum_we;
    logic                   clear;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_valid;
    logic [COUNT_W-1:0]     rd_data;
    logic                   ready;
    logic                   err;

    modport master (
        output accum_addr, accum_din, accum_we, clear, rd_en, rd_addr,
        input  rd_valid, rd_data, ready, err
    );

    modport slave (
        input  accum_addr, accum_din, accum_we, clear, rd_en, rd_addr,
        output rd_valid, rd_data, ready, err
    );

endinterface

// File: rtl/accum_table_ram.sv
// ---------------------------------------------------------------------------
// accum_ram
// Simple dual-port RAM, one write port and one read port, registered read
// with one cycle of latency. A read and a write to the same address in the
// same cycle return the old contents (read-first).
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (sampled every cycle)
//   o_rdata : read data, one cycle after i_raddr
// ---------------------------------------------------------------------------
module accum_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/accum_table.sv
// ---------------------------------------------------------------------------
// accum_table
// Per-key 64-bit count store. Each accepted update does a read-modify-write
// of one RAM entry over two cycles; back-to-back updates to the same entry
// are forwarded so one update per cycle is sustained. The host can read
// entries and zero the whole table with a clear sweep.
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : accum_table_if.slave (update stream, clear, read port, ready, err)
// Build option: define ACCUM_SATURATE_EN to clamp sums at 2**64-1 (and flag
// err) instead of wrapping.
//
// state | meaning
// INIT  | after reset; sweep writes 0 to every entry
// RUN   | table zeroed, updates and reads accepted
// CLEAR | host-requested sweep, same as INIT
// ---------------------------------------------------------------------------
module accum_table
    import wordcount_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    accum_table_if.slave bus
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    accum_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_sweep;

    accum_req_t         w_req;
    logic               w_run, w_sweeping, w_in_range;
    logic               w_upd_acc, w_rd_acc, w_err_set, w_clamp;

    logic               r_p1_valid, r_p1_init;
    logic [ADDR_W-1:0]  r_p1_addr;
    logic [COUNT_W-1:0] r_p1_inc;

    logic               r_last_valid;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [COUNT_W-1:0] r_last_sum;

    logic               r_rd_pend, r_rd_valid;
    logic [COUNT_W-1:0] r_rd_data;
    logic               r_err;

    logic [COUNT_W-1:0] w_ram_rdata, w_old, w_sum;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_waddr, w_ram_raddr;
    logic [COUNT_W-1:0] w_ram_wdata;

    assign w_req = '{init:      bus.accum_din[COUNT_W],
                     increment: bus.accum_din[COUNT_W-1:0],
                     addr:      bus.accum_addr};

    assign w_run      = (r_state == RUN);
    assign w_sweeping = !w_run;
    assign w_in_range = (w_req.addr[31:ADDR_W] == '0);
    assign w_upd_acc  = w_run && bus.accum_we && w_in_range;
    // updates own the RAM read port; a read collides with any strobe
    assign w_rd_acc   = w_run && bus.rd_en && !bus.accum_we;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT, CLEAR: if (r_sweep == LAST_ADDR) w_state_nxt = RUN;
            RUN:         if (bus.clear) w_state_nxt = CLEAR;
            default:     w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            // wraps to 0 on the last entry, ready for the next sweep
            r_sweep <= w_sweeping ? r_sweep + 1'b1 : '0;
        end
    end

    // The previous cycle's sum was written to RAM after this entry's read
    // was issued, so take it from the register instead.
    assign w_old = (r_last_valid && (r_last_addr == r_p1_addr)) ? r_last_sum
                                                                : w_ram_rdata;

`ifdef ACCUM_SATURATE_EN
    logic [COUNT_W:0] w_sum_full;

    always_comb begin
        w_sum_full = {1'b0, w_old} + {1'b0, r_p1_inc};
        w_clamp    = r_p1_valid && !r_p1_init && w_sum_full[COUNT_W];
        if (r_p1_init) begin
            w_sum = r_p1_inc;
        end else if (w_sum_full[COUNT_W]) begin
            w_sum = '1;
        end else begin
            w_sum = w_sum_full[COUNT_W-1:0];
        end
    end
`else
    always_comb begin
        w_clamp = 1'b0;
        w_sum   = r_p1_init ? r_p1_inc : (w_old + r_p1_inc);
    end
`endif

    assign w_err_set = (bus.accum_we && !w_upd_acc) || w_clamp;

    // The sweep owns the write port; an in-flight commit it displaces would
    // be zeroed by the same sweep anyway.
    assign w_ram_we    = w_sweeping || r_p1_valid;
    assign w_ram_waddr = w_sweeping ? r_sweep : r_p1_addr;
    assign w_ram_wdata = w_sweeping ? '0 : w_sum;
    assign w_ram_raddr = w_upd_acc ? w_req.addr[ADDR_W-1:0] : bus.rd_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_valid   <= 1'b0;
            r_p1_init    <= 1'b0;
            r_p1_addr    <= '0;
            r_p1_inc     <= '0;
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
            r_last_sum   <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_p1_valid   <= w_upd_acc;
            r_p1_init    <= w_req.init;
            r_p1_addr    <= w_req.addr[ADDR_W-1:0];
            r_p1_inc     <= w_req.increment;
            r_last_valid <= r_p1_valid && !w_sweeping;
            r_last_addr  <= r_p1_addr;
            r_last_sum   <= w_sum;
            r_rd_pend    <= w_rd_acc;
            r_rd_valid   <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= w_ram_rdata;
            end
            r_err        <= r_err || w_err_set;
        end
    end

    accum_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (COUNT_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign bus.ready    = w_run;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_accum_table.sv
module tb_accum_table;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst_n;

    accum_table_if #(.ADDR_W(ADDR_W)) bus ();

    accum_table #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // reference table: one counter per key, updated when the update is issued
    logic [63:0] m_tab [DEPTH];
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_upd(input logic [31:0] a, input logic ini, input logic [63:0] inc);
        logic [64:0] s;
        if (a >= DEPTH) begin
            m_err = 1'b1;
            return;
        end
        if (ini) begin
            m_tab[a] = inc;
        end else begin
            s = {1'b0, m_tab[a]} + {1'b0, inc};
`ifdef ACCUM_SATURATE_EN
            if (s[64]) begin
                s[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
                m_err   = 1'b1;
            end
`endif
            m_tab[a] = s[63:0];
        end
    endfunction

    task automatic upd(input logic [31:0] a, input logic ini, input logic [63:0] inc);
        bus.accum_addr = a;
        bus.accum_din  = {ini, inc};
        bus.accum_we   = 1'b1;
        m_upd(a, ini, inc);
        @(negedge clk);
        bus.accum_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input logic [ADDR_W-1:0] a, input logic [63:0] exp, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        chk(tag, bus.rd_data, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.rd_valid), 64'd0);
    endtask

    task automatic do_reset();
        int n;
        bus.accum_we = 1'b0;
        bus.clear    = 1'b0;
        bus.rd_en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        m_err = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("init_sweep_len", 64'(n), 64'(DEPTH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        ini;
        logic [63:0] inc;
        int          n;

        rst_n          = 1'b0;
        bus.accum_addr = '0;
        bus.accum_din  = '0;
        bus.accum_we   = 1'b0;
        bus.clear      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        m_err = 1'b0;

        idle(2);
        chk("rst_ready",    64'(bus.ready),    64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data",  bus.rd_data,       64'd0);
        chk("rst_err",      64'(bus.err),      64'd0);

        // release, then reset again mid-sweep: the sweep must restart at 0
        rst_n = 1'b1;
        idle(100);
        do_reset();

        rd_chk(10'd0,    64'd0, "zero_0");
        rd_chk(10'd511,  64'd0, "zero_511");
        rd_chk(10'd1023, 64'd0, "zero_1023");
        chk("err_after_init", 64'(bus.err), 64'd0);

        // init then accumulate with a gap
        upd(32'd3, 1'b1, 64'd5);
        idle(4);
        upd(32'd3, 1'b0, 64'd7);
        idle(2);
        rd_chk(10'd3, 64'd12, "acc_gap");

        // run of consecutive hits on one key
        upd(32'd7, 1'b1, 64'd1);
        repeat (8) upd(32'd7, 1'b0, 64'd1);
        idle(2);
        rd_chk(10'd7, 64'd9, "fwd_run");

        // random traffic over a small key range with random gaps
        for (int i = 0; i < 200; i++) begin
            a   = 32'($urandom_range(15, 0));
            ini = ($urandom_range(7, 0) == 0);
            inc = {32'd0, $urandom()};
            upd(a, ini, inc);
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
        end
        idle(2);
        for (int k = 0; k < 16; k++) rd_chk(ADDR_W'(k), m_tab[k], "rand");
        chk("err_after_rand", 64'(bus.err), 64'(m_err));

        // read colliding with an update is dropped; the retry succeeds
        bus.accum_addr = 32'd2;
        bus.accum_din  = {1'b1, 64'd4};
        bus.accum_we   = 1'b1;
        m_upd(32'd2, 1'b1, 64'd4);
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 10'd3;
        @(negedge clk);
        bus.accum_we = 1'b0;
        chk("coll_t1_valid", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("coll_rejected", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        chk("coll_retry_valid", 64'(bus.rd_valid), 64'd1);
        chk("coll_retry_data",  bus.rd_data,       m_tab[3]);
        idle(2);
        rd_chk(10'd2, m_tab[2], "coll_upd");

        // near-full counter plus 3: wraps or clamps depending on build
        upd(32'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(3);
        upd(32'd9, 1'b0, 64'd3);
        idle(2);
        rd_chk(10'd9, m_tab[9], "ovf9");
        chk("err_ovf", 64'(bus.err), 64'(m_err));

        // reset re-zeroes the table and err
        do_reset();
        rd_chk(10'd3, 64'd0, "rezero3");
        chk("err_after_reset", 64'(bus.err), 64'd0);

        // out-of-range key (aliases index 0) is dropped and flags err
        upd(32'h400, 1'b0, 64'd123);
        idle(2);
        rd_chk(10'd0, m_tab[0], "oor_unchanged");
        chk("err_oor", 64'(bus.err), 64'(m_err));

        // clear sweep, with an update in the clear cycle and one during CLEAR
        do_reset();
        upd(32'd5, 1'b1, 64'd77);
        idle(2);
        rd_chk(10'd5, 64'd77, "pre_clear");
        bus.clear = 1'b1;
        upd(32'd6, 1'b1, 64'd88);
        bus.clear = 1'b0;
        chk("clear_ready_fall", 64'(bus.ready), 64'd0);
        bus.accum_addr = 32'd6;
        bus.accum_din  = {1'b0, 64'd1};
        bus.accum_we   = 1'b1;
        m_err          = 1'b1;
        @(negedge clk);
        bus.accum_we = 1'b0;
        n = 1;
        while (bus.ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_sweep_len", 64'(n), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        chk("err_we_in_clear", 64'(bus.err), 64'(m_err));
        rd_chk(10'd5, m_tab[5], "cleared5");
        rd_chk(10'd6, m_tab[6], "cleared6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
